immgen_skid: RTL

Registered, parametrised successor to the ID-stage immediate generator. It accepts a decoded immediate selector and instruction bits over a valid/ready handshake and produces an XLEN-wide immediate one cycle later. A 2-entry skid buffer lets ID stall without a combinational ready path. It adds CSR zimm and shift-amount formats, an illegal-selector flag, and a flush input. It sits between the ID decoder and the ID/EX pipeline register.

---
 rtl/immgen_skid_pkg.sv | 25 ++
 rtl/immgen_skid_core.sv | 32 +++
 rtl/immgen_skid.sv | 100 ++++++++++
 3 files changed

// File: rtl/immgen_skid_pkg.sv
// Shared types for the registered immediate generator: format selector,
// skid occupancy encoding and the XLEN legality check.
package immgen_skid_pkg;

    typedef enum logic [2:0] {
        IMMGEN_I     = 3'd0,
        IMMGEN_S     = 3'd1,
        IMMGEN_SB    = 3'd2,
        IMMGEN_UJ    = 3'd3,
        IMMGEN_U     = 3'd4,
        IMMGEN_Z     = 3'd5,
        IMMGEN_SHAMT = 3'd6
    } immgen_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    function automatic bit xlen_legal(int unsigned x);
        return (x == 32) || (x == 64);
    endfunction

endpackage

// File: rtl/immgen_skid_core.sv
// Combinational immediate former: (sel, instr[31:7]) -> (imm, illegal).
module immgen_skid_core
    import immgen_skid_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  immgen_t          sel,
    input  logic [24:0]      instr,
    output logic [XLEN-1:0]  imm,
    output logic             illegal
);

    // Indexed as real instruction bits so the formats read like the ISA manual.
    logic [31:7] r;
    assign r = instr;

    always_comb begin
        imm     = '0;
        illegal = 1'b0;
        case (sel)
            IMMGEN_I:     imm = XLEN'($signed(r[31:20]));
            IMMGEN_S:     imm = XLEN'($signed({r[31:25], r[11:7]}));
            IMMGEN_SB:    imm = XLEN'($signed({r[31], r[7], r[30:25], r[11:8], 1'b0}));
            IMMGEN_UJ:    imm = XLEN'($signed({r[31], r[19:12], r[20], r[30:21], 1'b0}));
            IMMGEN_U:     imm = XLEN'($signed({r[31:12], 12'b0}));
            IMMGEN_Z:     imm = XLEN'(r[19:15]);
            IMMGEN_SHAMT: imm = (XLEN == 64) ? XLEN'(r[25:20]) : XLEN'(r[24:20]);
            default:      illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/immgen_skid.sv
// Registered immediate generator with a 2-entry skid buffer between the
// ID decoder and the ID/EX register; in_ready depends on state only.
module immgen_skid
    import immgen_skid_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  immgen_t           in_sel,
    input  logic [24:0]       in_instr,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_imm,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_illegal
);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("immgen_skid: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } entry_t;

    occ_t   st, nxt;
    entry_t m, k, new_e;
    logic   m_vld, accept, drain;
    logic   ld_m_new, ld_m_k, ld_k;

    immgen_skid_core #(.XLEN(XLEN)) u_core (
        .sel     (in_sel),
        .instr   (in_instr),
        .imm     (new_e.imm),
        .illegal (new_e.illegal)
    );
    assign new_e.tag = in_tag;

    assign m_vld    = (st != OCC_EMPTY);
    assign in_ready = (st != OCC_FULL);
    assign accept   = in_valid && in_ready;
    assign drain    = m_vld && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= OCC_EMPTY;
        else     st <= nxt;
    end

    always_comb begin
        nxt      = st;
        ld_m_new = 1'b0;
        ld_m_k   = 1'b0;
        ld_k     = 1'b0;
        case (st)
            OCC_EMPTY: if (accept) begin
                nxt      = OCC_ONE;
                ld_m_new = 1'b1;
            end
            OCC_ONE: case ({accept, drain})
                2'b10:   begin nxt = OCC_FULL; ld_k = 1'b1; end
                2'b01:   nxt = OCC_EMPTY;
                2'b11:   ld_m_new = 1'b1;
                default: ;
            endcase
            OCC_FULL: if (drain) begin
                nxt    = OCC_ONE;
                ld_m_k = 1'b1;
            end
            default: nxt = OCC_EMPTY;
        endcase
        // Flush wins over any concurrent accept or drain.
        if (flush) begin
            nxt      = OCC_EMPTY;
            ld_m_new = 1'b0;
            ld_m_k   = 1'b0;
            ld_k     = 1'b0;
        end
    end

    // Payload registers carry no reset; outputs are gated by the valid state.
    always_ff @(posedge clk) begin
        if (ld_m_new)    m <= new_e;
        else if (ld_m_k) m <= k;
        if (ld_k)        k <= new_e;
    end

    assign out_valid   = m_vld;
    assign out_imm     = m_vld ? m.imm     : '0;
    assign out_tag     = m_vld ? m.tag     : '0;
    assign out_illegal = m_vld ? m.illegal : 1'b0;

endmodule
